coin_anim_ctrl: RTL and testbench
=================================

COIN_ANIM_CTRL -- requirements
Module: coin_anim_ctrl

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 4: vsync frames per animation frame step, legal range 1..255.
REQ-002 SHALL have parameter FLASH_FRAMES, default 30: vsync frames in the COLLECTED blink phase, legal range 1..255.
REQ-003 SHALL have parameter RESPAWN_FRAMES, default 120: vsync frames hidden before auto-respawn, legal range 1..255.
REQ-004 SHALL have port vga_clk  in  1  pixel clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port vsync  in  1  VGA vertical sync, active-low; synchronous to vga_clk.
REQ-007 SHALL have ports DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-008 SHALL have ports coin_x, coin_y  in  10 each  coin top-left position; sampled only at a frame tick.
REQ-009 SHALL have port spawn  in  1  one-cycle request to show the coin.
REQ-010 SHALL have port collect  in  1  one-cycle pickup event.
REQ-011 SHALL have port rom_address  out  13  address into the 256x32 silver-coin sheet: 8 frames of 32x32, frame f in columns f*32..f*32+31.
REQ-012 SHALL have port coin_on  out  1  current pixel is inside a visible coin.
REQ-013 SHALL have port collected  out  1  one-cycle pulse on COLLECTED->WAIT.
REQ-014 SHALL have port anim_state  out  2  IDLE=0, SPIN=1, COLLECTED=2, WAIT=3.

Function
REQ-015 SHALL generate a frame tick on the vga_clk cycle after vsync is seen falling (registered previous value 1, current value 0); exactly one tick per vsync falling edge.
REQ-016 SHALL latch coin_x and coin_y into pos_x and pos_y on each frame tick; rom_address and coin_on use only the latched values.
REQ-017 SHALL, in IDLE: coin_on = 0 and frame index = 0; spawn -> SPIN with frame index 0 and divider 0.
REQ-018 SHALL, in SPIN: increment the divider on each tick; when it reaches FRAME_DIV-1, clear it and advance the frame index, wrapping 7->0.
REQ-019 SHALL, in SPIN: collect -> COLLECTED on the next edge, freezing the frame index and clearing the flash counter.
REQ-020 SHALL, in COLLECTED: count ticks; coin visible only while flash counter bit 2 = 0; at FLASH_FRAMES ticks -> WAIT with collected = 1 for that single cycle.
REQ-021 SHALL, in WAIT: coin_on = 0; count ticks; at RESPAWN_FRAMES ticks -> SPIN with frame index 0; spawn -> SPIN immediately.
REQ-022 SHALL ignore spawn in SPIN and COLLECTED, and ignore collect outside SPIN.
REQ-023 SHALL give collect priority when spawn and collect are asserted together in SPIN.
REQ-024 SHALL have the state counter update first when a tick coincides with a state transition: the new state's counter starts at 0, and that tick is not counted.
REQ-025 SHALL compute rx = DrawX - pos_x and ry = DrawY - pos_y as 10-bit unsigned values; inside = rx < 32 and ry < 32, with wrap on underflow yielding outside.
REQ-026 SHALL drive coin_on = inside AND visible, where visible is set by state per REQ-017/020/021 and is 1 in SPIN.
REQ-027 SHALL drive rom_address = ry[4:0]*256 + frame*32 + rx[4:0] combinationally, so the downstream ROM, clocked on the negative edge, returns data by the next rising edge.
REQ-028 SHALL drive rom_address = 0 when inside = 0.
REQ-029 SHALL register anim_state and collected; coin_on and rom_address are combinational from DrawX/DrawY and registered state.

Reset
REQ-030 SHALL, while Reset is high, force state IDLE, frame index 0, all counters 0, pos_x = pos_y = 0, vsync history = 1, collected = 0, anim_state = 0, and therefore coin_on = 0.
REQ-031 SHALL, on Reset mid-SPIN or mid-COLLECTED, abandon the operation with no collected pulse; the coin stays in IDLE until spawn.

Verification
REQ-032 SHALL verify: Reset, then spawn, coin_x=100, coin_y=50, one vsync fall, DrawX=100, DrawY=50 -> coin_on=1, rom_address=0; DrawX=131, DrawY=81 -> rom_address=7967; DrawX=132 -> coin_on=0, rom_address=0.
REQ-033 SHALL verify: FRAME_DIV=4, SPIN, 4 ticks -> frame 1 (rom_address at rx=ry=0 is 32); 32 ticks -> frame wraps to 0.
REQ-034 SHALL verify: collect at frame 3 -> anim_state=2, frame held at 3, coin_on toggles every 4 ticks; after 30 ticks -> collected pulse 1 cycle, anim_state=3, coin_on=0.
REQ-035 SHALL verify: WAIT, 120 ticks -> anim_state=1, frame 0; separately, spawn on WAIT tick 5 -> SPIN on the next edge.
REQ-036 SHALL verify: spawn and collect in the same cycle in SPIN -> COLLECTED; collect in IDLE -> no change.
REQ-037 SHALL verify: coin_x=620, DrawX=5 -> coin_on=0 (no wrap); Reset asserted mid-COLLECTED -> anim_state=0 asynchronously, with no collected pulse.

Source files
------------

// File: rtl/coin_anim_ctrl.sv
// Coin sprite animation controller: spin, collect flash, respawn.
// Ports: vga_clk/Reset, vsync, DrawX/DrawY, coin_x/coin_y, spawn, collect -> rom_address, coin_on, collected, anim_state.
module coin_anim_ctrl #(
  parameter int FRAME_DIV      = 4,
  parameter int FLASH_FRAMES   = 30,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  coin_x,
  input  logic [9:0]  coin_y,
  input  logic        spawn,
  input  logic        collect,
  output logic [12:0] rom_address,
  output logic        coin_on,
  output logic        collected,
  output logic [1:0]  anim_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SPIN = 2'd1,
    S_COLL = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] L_DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [8:0] L_FLASH    = 9'(FLASH_FRAMES);
  localparam logic [8:0] L_RESP     = 9'(RESPAWN_FRAMES);

  state_t      r_state;
  logic [2:0]  r_frame;
  logic [7:0]  r_cnt;
  logic [9:0]  r_pos_x;
  logic [9:0]  r_pos_y;
  logic        r_vs_prev;
  logic        r_collected;

  logic        w_tick;
  logic [8:0]  w_cnt_inc;
  logic [9:0]  w_rx;
  logic [9:0]  w_ry;
  logic        w_inside;
  logic        w_vis;

  assign w_tick    = r_vs_prev & ~vsync;
  // one bit wider so a count of 255 compares without overflow
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_cnt       <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_vs_prev   <= 1'b1;
      r_collected <= 1'b0;
    end else begin
      r_vs_prev   <= vsync;
      r_collected <= 1'b0;
      if (w_tick) begin
        r_pos_x <= coin_x;
        r_pos_y <= coin_y;
      end
      // a transition clears the counter and swallows a coincident tick
      unique case (r_state)
        S_IDLE: begin
          if (spawn) begin
            r_state <= S_SPIN;
            r_frame <= '0;
            r_cnt   <= '0;
          end
        end
        S_SPIN: begin
          if (collect) begin
            r_state <= S_COLL;
            r_cnt   <= '0;
          end else if (w_tick) begin
            if (r_cnt == L_DIV_LAST) begin
              r_cnt   <= '0;
              r_frame <= r_frame + 3'd1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_COLL: begin
          if (w_tick) begin
            if (w_cnt_inc == L_FLASH) begin
              r_state     <= S_WAIT;
              r_cnt       <= '0;
              r_collected <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc[7:0];
            end
          end
        end
        S_WAIT: begin
          if (spawn) begin
            r_state <= S_SPIN;
            r_frame <= '0;
            r_cnt   <= '0;
          end else if (w_tick) begin
            if (w_cnt_inc == L_RESP) begin
              r_state <= S_SPIN;
              r_frame <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc[7:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // underflow wraps to a large value, so it lands outside
  assign w_rx     = DrawX - r_pos_x;
  assign w_ry     = DrawY - r_pos_y;
  assign w_inside = (w_rx[9:5] == 5'd0) && (w_ry[9:5] == 5'd0);

  always_comb begin
    w_vis = 1'b0;
    unique case (r_state)
      S_SPIN:  w_vis = 1'b1;
      S_COLL:  w_vis = ~r_cnt[2];
      default: w_vis = 1'b0;
    endcase
  end

  assign coin_on     = w_inside & w_vis;
  assign rom_address = w_inside ? {w_ry[4:0], r_frame, w_rx[4:0]} : 13'd0;
  assign collected   = r_collected;
  assign anim_state  = r_state;

endmodule

// File: tb/tb_coin_anim_ctrl.sv
// Testbench for coin_anim_ctrl: directed scenarios plus random traffic
// compared every cycle against a tick-counting reference model.
module tb_coin_anim_ctrl;

  localparam int FD   = 4;
  localparam int FLSH = 30;
  localparam int RESP = 120;

  logic        vga_clk;
  logic        Reset;
  logic        vsync;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  coin_x;
  logic [9:0]  coin_y;
  logic        spawn;
  logic        collect;
  logic [12:0] rom_address;
  logic        coin_on;
  logic        collected;
  logic [1:0]  anim_state;

  int n_checks = 0;
  int n_errors = 0;

  // model: mode, ticks counted since entering mode, frozen frame
  int m_mode;
  int m_ticks;
  int m_frz;
  int m_px;
  int m_py;
  int m_vprev;
  int m_pulse;

  coin_anim_ctrl #(
    .FRAME_DIV(FD),
    .FLASH_FRAMES(FLSH),
    .RESPAWN_FRAMES(RESP)
  ) dut (
    .vga_clk(vga_clk),
    .Reset(Reset),
    .vsync(vsync),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .coin_x(coin_x),
    .coin_y(coin_y),
    .spawn(spawn),
    .collect(collect),
    .rom_address(rom_address),
    .coin_on(coin_on),
    .collected(collected),
    .anim_state(anim_state)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_ticks = 0;
    m_frz   = 0;
    m_px    = 0;
    m_py    = 0;
    m_vprev = 1;
    m_pulse = 0;
  endtask

  function automatic int spin_frame();
    return (m_ticks / FD) % 8;
  endfunction

  task automatic model_update();
    bit tick;
    if (Reset) begin
      model_reset();
      return;
    end
    tick    = (m_vprev == 1) && (vsync == 1'b0);
    m_vprev = int'(vsync);
    m_pulse = 0;
    case (m_mode)
      0: if (spawn) begin
        m_mode = 1; m_ticks = 0;
      end
      1: if (collect) begin
        m_frz = spin_frame(); m_mode = 2; m_ticks = 0;
      end else if (tick) m_ticks++;
      2: if (tick) begin
        m_ticks++;
        if (m_ticks == FLSH) begin
          m_mode = 3; m_ticks = 0; m_pulse = 1;
        end
      end
      default: if (spawn) begin
        m_mode = 1; m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == RESP) begin
          m_mode = 1; m_ticks = 0;
        end
      end
    endcase
    if (tick) begin
      m_px = int'(coin_x);
      m_py = int'(coin_y);
    end
  endtask

  task automatic check_all();
    int rx, ry, fr, vis, ins, rom;
    rx  = (int'(DrawX) - m_px) & 1023;
    ry  = (int'(DrawY) - m_py) & 1023;
    ins = (rx < 32 && ry < 32) ? 1 : 0;
    case (m_mode)
      1: begin fr = spin_frame(); vis = 1; end
      2: begin fr = m_frz; vis = ((m_ticks / 4) % 2 == 0) ? 1 : 0; end
      3: begin fr = m_frz; vis = 0; end
      default: begin fr = 0; vis = 0; end
    endcase
    rom = ins ? (ry % 32) * 256 + fr * 32 + (rx % 32) : 0;
    chk("state", 32'(anim_state), 32'(m_mode));
    chk("pulse", 32'(collected), 32'(m_pulse));
    chk("coin_on", 32'(coin_on), 32'(ins & vis));
    if (!(m_mode == 3 && ins == 1))
      chk("rom", 32'(rom_address), 32'(rom));
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    model_update();
    @(negedge vga_clk);
    check_all();
  endtask

  task automatic vs_tick();
    vsync = 1'b0;
    cyc();
    vsync = 1'b1;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) vs_tick();
  endtask

  task automatic pulse_spawn();
    spawn = 1'b1;
    cyc();
    spawn = 1'b0;
  endtask

  task automatic pulse_collect();
    collect = 1'b1;
    cyc();
    collect = 1'b0;
  endtask

  initial begin
    int vs_left;
    Reset   = 1'b1;
    vsync   = 1'b1;
    DrawX   = 10'd0;
    DrawY   = 10'd0;
    coin_x  = 10'd0;
    coin_y  = 10'd0;
    spawn   = 1'b0;
    collect = 1'b0;
    model_reset();
    @(negedge vga_clk);
    cyc();
    cyc();
    chk("rst_state", 32'(anim_state), 32'd0);
    chk("rst_coin_on", 32'(coin_on), 32'd0);
    Reset = 1'b0;
    cyc();

    // placement and pixel addressing
    coin_x = 10'd100;
    coin_y = 10'd50;
    pulse_spawn();
    vs_tick();
    DrawX = 10'd100; DrawY = 10'd50;
    cyc();
    chk("org_on", 32'(coin_on), 32'd1);
    chk("org_rom", 32'(rom_address), 32'd0);
    DrawX = 10'd131; DrawY = 10'd81;
    cyc();
    chk("corner_rom", 32'(rom_address), 32'd7967);
    DrawX = 10'd132;
    cyc();
    chk("right_on", 32'(coin_on), 32'd0);
    chk("right_rom", 32'(rom_address), 32'd0);

    // frame stepping and wrap
    DrawX = 10'd100; DrawY = 10'd50;
    ticks(3);
    chk("frame1_rom", 32'(rom_address), 32'd32);
    ticks(28);
    chk("wrap_rom", 32'(rom_address), 32'd0);
    ticks(12);
    chk("frame3_rom", 32'(rom_address), 32'd96);

    // collect and flash
    pulse_collect();
    chk("coll_state", 32'(anim_state), 32'd2);
    chk("coll_rom", 32'(rom_address), 32'd96);
    chk("flash_on0", 32'(coin_on), 32'd1);
    ticks(4);
    chk("flash_off", 32'(coin_on), 32'd0);
    ticks(4);
    chk("flash_on1", 32'(coin_on), 32'd1);
    ticks(21);
    chk("coll_hold", 32'(anim_state), 32'd2);
    vsync = 1'b0;
    cyc();
    chk("coll_pulse", 32'(collected), 32'd1);
    chk("wait_state", 32'(anim_state), 32'd3);
    chk("wait_on", 32'(coin_on), 32'd0);
    vsync = 1'b1;
    cyc();
    chk("pulse_end", 32'(collected), 32'd0);

    // auto respawn
    ticks(119);
    chk("wait_hold", 32'(anim_state), 32'd3);
    ticks(1);
    chk("respawn", 32'(anim_state), 32'd1);
    chk("respawn_rom", 32'(rom_address), 32'd0);

    // manual respawn on a tick
    pulse_collect();
    ticks(30);
    chk("wait2", 32'(anim_state), 32'd3);
    ticks(4);
    vsync = 1'b0;
    spawn = 1'b1;
    cyc();
    spawn = 1'b0;
    chk("spawn_wait", 32'(anim_state), 32'd1);
    vsync = 1'b1;
    cyc();

    // collect wins over spawn, then async reset
    spawn = 1'b1; collect = 1'b1;
    cyc();
    spawn = 1'b0; collect = 1'b0;
    chk("both", 32'(anim_state), 32'd2);
    ticks(2);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("async_state", 32'(anim_state), 32'd0);
    chk("async_pulse", 32'(collected), 32'd0);
    chk("async_on", 32'(coin_on), 32'd0);
    cyc();
    Reset = 1'b0;
    cyc();
    pulse_collect();
    chk("idle_collect", 32'(anim_state), 32'd0);

    // no horizontal wrap
    coin_x = 10'd620; coin_y = 10'd50;
    pulse_spawn();
    vs_tick();
    DrawX = 10'd5; DrawY = 10'd50;
    cyc();
    chk("nowrap", 32'(coin_on), 32'd0);
    DrawX = 10'd620;
    cyc();
    chk("edge_on", 32'(coin_on), 32'd1);

    // random traffic
    vs_left = 3;
    for (int i = 0; i < 8000; i++) begin
      Reset   = ($urandom_range(0, 1999) == 0);
      spawn   = ($urandom_range(0, 299) == 0);
      collect = ($urandom_range(0, 99) == 0);
      if (vs_left == 0) begin
        vsync   = ~vsync;
        vs_left = vsync ? $urandom_range(1, 4) : $urandom_range(1, 3);
      end else begin
        vs_left--;
      end
      if ($urandom_range(0, 199) == 0) begin
        coin_x = 10'($urandom);
        coin_y = 10'($urandom);
      end
      DrawX = 10'(m_px + $urandom_range(0, 40) - 4);
      DrawY = 10'(m_py + $urandom_range(0, 40) - 4);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
